// File: rtl/periph_fabric_pkg.sv
// Shared constants for the peripheral fabric: FSM encodings, control register
// offsets, the default timeout and the control-block address match.
package periph_fabric_pkg;

  // Fabric FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Control register word offsets (addr[3:2])
  localparam logic [1:0] REG_PENDING  = 2'd0;
  localparam logic [1:0] REG_MASK     = 2'd1;
  localparam logic [1:0] REG_ACK      = 2'd2;
  localparam logic [1:0] REG_ERR_ADDR = 2'd3;

  localparam int unsigned TMO_DEFAULT = 255;

  // The control block is a 16-byte window, so only addr[31:4] takes part
  function automatic logic ctrl_match(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/periph_fabric_irq_aggregator.sv
// Edge-triggered interrupt aggregator: rising-edge capture into pending,
// software mask, write-1-to-clear acknowledge and a registered combined IRQ.
module periph_fabric_irq_aggregator #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk50M,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               ack_we,
  input  logic [NUM_IRQ-1:0] ack_wdata,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] clr;

  assign clr = ack_we ? ack_wdata : '0;

  // Edge capture, W1C (a new edge in the same cycle wins), mask and IRQ output
  always_ff @(posedge clk50M) begin
    if (rst) begin
      irq_d   <= '0;
      pending <= '0;
      mask    <= '0;
      irq_out <= 1'b0;
    end else begin
      irq_d   <= irq_in;
      pending <= (pending & ~clr) | (irq_in & ~irq_d);
      if (mask_we) mask <= mask_wdata;
      irq_out <= |(pending & mask);
    end
  end

endmodule

// File: rtl/periph_fabric.sv
// Peripheral interconnect: decodes CPU accesses onto NUM_SLAVES memory-mapped
// devices with req/ack handshake and timeout, reports bus errors, and hosts a
// small control block (interrupt pending/mask/ack, last error address).
module periph_fabric import periph_fabric_pkg::*; #(
  parameter int unsigned              NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h1E000000, 32'h00000000,
                                                    32'h1FD003F8, 32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {32'hFF000000, 32'hFFE00000,
                                                    32'hFFFFFFF8, 32'hFFC00000},
  parameter logic [31:0]              CTRL_BASE  = 32'h1FD00400,
  parameter int unsigned              TIMEOUT    = TMO_DEFAULT,
  parameter int unsigned              TMO_W      = 8,
  parameter int unsigned              NUM_IRQ    = 8
) (
  input  logic                     clk50M,
  input  logic                     rst,
  input  logic                     cpu_start,
  input  logic [31:0]              cpu_addr,
  input  logic                     cpu_is_write,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_busy,
  output logic                     cpu_err,
  output logic [NUM_SLAVES-1:0]    slv_sel,
  output logic [31:0]              slv_addr,
  output logic [31:0]              slv_wdata,
  output logic                     slv_we,
  input  logic [NUM_SLAVES*32-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]    slv_ack,
  input  logic [NUM_IRQ-1:0]       irq_in,
  output logic                     irq_out
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [1:0]         state;
  logic [TMO_W-1:0]   cnt;
  logic [IDX_W-1:0]   sel_idx;
  logic [31:0]        err_addr;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               is_ctrl;
  logic               reg_op;
  logic [1:0]         reg_off;
  logic [31:0]        reg_rdata;
  logic               mask_we;
  logic               ack_we;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;

  assign is_ctrl = ctrl_match(slv_addr, CTRL_BASE);
  assign reg_off = slv_addr[3:2];
  assign reg_op  = (state == ST_DECODE) && is_ctrl;
  assign mask_we = reg_op && slv_we && (reg_off == REG_MASK);
  assign ack_we  = reg_op && slv_we && (reg_off == REG_ACK);

  // Priority decode: scanning downwards leaves the lowest-index hit in dec_idx
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((slv_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  // Control register read mux; unused bits read as zero
  always_comb begin
    reg_rdata = '0;
    case (reg_off)
      REG_PENDING:  reg_rdata[NUM_IRQ-1:0] = pending;
      REG_MASK:     reg_rdata[NUM_IRQ-1:0] = mask;
      REG_ERR_ADDR: reg_rdata = err_addr;
      default:      reg_rdata = '0;
    endcase
  end

  // Access FSM: latch request, decode, run handshake with timeout, report result
  always_ff @(posedge clk50M) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sel_idx   <= '0;
      err_addr  <= '0;
      cpu_rdata <= '0;
      cpu_busy  <= 1'b0;
      cpu_err   <= 1'b0;
      slv_sel   <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      slv_we    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_start) begin
            slv_addr  <= cpu_addr;
            slv_wdata <= cpu_wdata;
            slv_we    <= cpu_is_write;
            cpu_busy  <= 1'b1;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_ctrl) begin
            cpu_rdata <= slv_we ? 32'h0 : reg_rdata;
            cpu_err   <= 1'b0;
            cpu_busy  <= 1'b0;
            state     <= ST_IDLE;
          end else if (dec_hit) begin
            slv_sel <= NUM_SLAVES'(1) << dec_idx;
            sel_idx <= dec_idx;
            cnt     <= '0;
            state   <= ST_ACCESS;
          end else begin
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
            err_addr  <= slv_addr;
            cpu_busy  <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // Ack is checked first so it wins over a coincident timeout
          if (slv_ack[sel_idx]) begin
            slv_sel   <= '0;
            cpu_rdata <= slv_we ? 32'h0 : slv_rdata[32*sel_idx +: 32];
            cpu_err   <= 1'b0;
            cpu_busy  <= 1'b0;
            state     <= ST_IDLE;
          end else if (cnt == TMO_W'(TIMEOUT)) begin
            slv_sel   <= '0;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
            err_addr  <= slv_addr;
            cpu_busy  <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  periph_fabric_irq_aggregator #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq (
    .clk50M     (clk50M),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (slv_wdata[NUM_IRQ-1:0]),
    .ack_we     (ack_we),
    .ack_wdata  (slv_wdata[NUM_IRQ-1:0]),
    .pending    (pending),
    .mask       (mask),
    .irq_out    (irq_out)
  );

endmodule
